// File: rtl/sine_tone_analyzer.sv
// Purpose: recovers tone period and peak amplitudes from a signed sine sample stream via hysteretic rising-crossing detection.
// Latency: result registered one clk after the closing rising-crossing sample is accepted.
// Backpressure: result held until result_ready; a new result while unread overwrites and sets sticky overrun.
module sine_tone_analyzer #(
    parameter int SINE_WIDTH   = 7,
    parameter int PERIOD_WIDTH = 16,
    parameter int HYST         = 2
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           sample_valid,
    input  logic signed [SINE_WIDTH-1:0]   sample,
    input  logic                           result_ready,
    output logic                           result_valid,
    output logic        [PERIOD_WIDTH-1:0] period,
    output logic signed [SINE_WIDTH-1:0]   peak_pos,
    output logic signed [SINE_WIDTH-1:0]   peak_neg,
    output logic                           lock,
    output logic                           overrun,
    output logic                           timeout
);

    // Most positive / most negative representable samples seed the trackers
    localparam logic signed [SINE_WIDTH-1:0] S_MAX    = {1'b0, {(SINE_WIDTH-1){1'b1}}};
    localparam logic signed [SINE_WIDTH-1:0] S_MIN    = {1'b1, {(SINE_WIDTH-1){1'b0}}};
    localparam logic signed [SINE_WIDTH-1:0] HYST_POS = SINE_WIDTH'(HYST);
    localparam logic signed [SINE_WIDTH-1:0] HYST_NEG = SINE_WIDTH'(-HYST);
    localparam logic [PERIOD_WIDTH-1:0]      CNT_MAX  = {PERIOD_WIDTH{1'b1}};
    // Counter value from which one more non-crossing sample saturates it
    localparam logic [PERIOD_WIDTH-1:0]      CNT_TOP  = {{(PERIOD_WIDTH-1){1'b1}}, 1'b0};

    typedef enum logic {
        ACQUIRE = 1'b0,
        TRACK   = 1'b1
    } state_t;

    state_t                         state;
    state_t                         state_nxt;
    logic                           armed;
    logic        [PERIOD_WIDTH-1:0] cnt;
    logic signed [SINE_WIDTH-1:0]   run_max;
    logic signed [SINE_WIDTH-1:0]   run_min;
    logic signed [SINE_WIDTH-1:0]   new_max;
    logic signed [SINE_WIDTH-1:0]   new_min;
    logic                           is_low;
    logic                           rise_hit;
    logic                           cnt_sat;

    // Crossing detection and running-extreme update for the current sample
    always_comb begin
        is_low   = 1'b0;
        rise_hit = 1'b0;
        cnt_sat  = 1'b0;
        new_max  = run_max;
        new_min  = run_min;
        if (sample_valid) begin
            is_low   = (sample <= HYST_NEG);
            rise_hit = armed && (sample >= HYST_POS);
            cnt_sat  = (state == TRACK) && !rise_hit && (cnt == CNT_TOP);
            new_max  = (sample > run_max) ? sample : run_max;
            new_min  = (sample < run_min) ? sample : run_min;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ACQUIRE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: lock on first crossing, drop lock when the counter saturates
    always_comb begin
        state_nxt = state;
        case (state)
            ACQUIRE: if (rise_hit) state_nxt = TRACK;
            TRACK:   if (cnt_sat)  state_nxt = ACQUIRE;
            default: state_nxt = ACQUIRE;
        endcase
    end

    assign lock = (state == TRACK);

    // Arming, period counter, peak trackers and result handshake
    always_ff @(posedge clk) begin
        if (reset) begin
            armed        <= 1'b0;
            cnt          <= '0;
            run_max      <= '0;
            run_min      <= '0;
            result_valid <= 1'b0;
            period       <= '0;
            peak_pos     <= '0;
            peak_neg     <= '0;
            overrun      <= 1'b0;
            timeout      <= 1'b0;
        end else begin
            timeout <= 1'b0;

            if (rise_hit) begin
                armed <= 1'b0;
            end else if (is_low) begin
                armed <= 1'b1;
            end

            // Consumer read; a same-cycle new result below takes priority
            if (result_ready) begin
                result_valid <= 1'b0;
            end

            if (state == ACQUIRE) begin
                if (rise_hit) begin
                    cnt     <= {{(PERIOD_WIDTH-1){1'b0}}, 1'b1};
                    run_max <= S_MIN;
                    run_min <= S_MAX;
                end
            end else if (sample_valid) begin
                if (rise_hit) begin
                    // cnt already includes the previous crossing sample
                    period       <= cnt;
                    peak_pos     <= new_max;
                    peak_neg     <= new_min;
                    result_valid <= 1'b1;
                    if (result_valid && !result_ready) begin
                        overrun <= 1'b1;
                    end
                    cnt     <= {{(PERIOD_WIDTH-1){1'b0}}, 1'b1};
                    run_max <= S_MIN;
                    run_min <= S_MAX;
                end else begin
                    if (cnt != CNT_MAX) begin
                        cnt <= cnt + 1'b1;
                    end
                    run_max <= new_max;
                    run_min <= new_min;
                    if (cnt_sat) begin
                        timeout <= 1'b1;
                    end
                end
            end
        end
    end

endmodule
